// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Turns the asynchronous PLL lock level into the design-wide synchronous
//   system reset. Lock has to stay continuously high for LOCK_STABLE_CYCLES
//   before a RESET_HOLD_CYCLES hold phase, after which sys_reset is released.
//   Losing lock while running re-asserts reset and is recorded for debug.
//
// Ports
//   clk           PLL output clock (only clock)
//   reset         synchronous active-high reset
//   locked_in     PLL lock level, asynchronous to clk
//   clear_sticky  one-cycle pulse clearing lock_lost / loss_count
//   sys_reset     registered active-high system reset
//   ready         registered, high exactly in RUN
//   state         debug: 0 WAIT_LOCK, 1 STABLE, 2 HOLD, 3 RUN
//   lock_lost     sticky flag, set on lock loss from RUN
//   loss_count    saturating count of lock losses from RUN
module pll_reset_sequencer #(
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned RESET_HOLD_CYCLES  = 16,
   parameter int unsigned COUNT_WIDTH        = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   locked_in,
   input  logic                   clear_sticky,
   output logic                   sys_reset,
   output logic                   ready,
   output logic [1:0]             state,
   output logic                   lock_lost,
   output logic [COUNT_WIDTH-1:0] loss_count
);

   localparam int unsigned MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                        LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t                 st;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   lock_s;
   logic                   run_loss;

   assign lock_s   = sync[SYNC_STAGES-1];
   assign run_loss = (st == RUN) && !lock_s;
   assign state    = st;

   // Synchronizer: the only place locked_in is sampled.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], locked_in};
      end
   end

   // Sequencer. sys_reset/ready are assigned alongside the next state so they
   // change on the same edge as state.
   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= WAIT_LOCK;
         cnt       <= '0;
         sys_reset <= 1'b1;
         ready     <= 1'b0;
      end else begin
         case (st)
            WAIT_LOCK: begin
               sys_reset <= 1'b1;
               ready     <= 1'b0;
               cnt       <= '0;
               if (lock_s) st <= STABLE;
            end
            STABLE: begin
               sys_reset <= 1'b1;
               ready     <= 1'b0;
               if (!lock_s) begin
                  st  <= WAIT_LOCK;
                  cnt <= '0;
               end else if (cnt == STABLE_LAST) begin
                  st  <= HOLD;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HOLD: begin
               if (!lock_s) begin
                  st        <= WAIT_LOCK;
                  cnt       <= '0;
                  sys_reset <= 1'b1;
                  ready     <= 1'b0;
               end else if (cnt == HOLD_LAST) begin
                  st        <= RUN;
                  cnt       <= '0;
                  sys_reset <= 1'b0;
                  ready     <= 1'b1;
               end else begin
                  cnt       <= cnt + CNT_W'(1);
                  sys_reset <= 1'b1;
                  ready     <= 1'b0;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  st        <= WAIT_LOCK;
                  sys_reset <= 1'b1;
                  ready     <= 1'b0;
               end else begin
                  sys_reset <= 1'b0;
                  ready     <= 1'b1;
               end
            end
            default: begin
               st        <= WAIT_LOCK;
               cnt       <= '0;
               sys_reset <= 1'b1;
               ready     <= 1'b0;
            end
         endcase
      end
   end

   // Loss-from-RUN bookkeeping. A loss on the same edge as a clear wins and
   // restarts the count at one.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_lost  <= 1'b0;
         loss_count <= '0;
      end else if (run_loss) begin
         lock_lost <= 1'b1;
         if (clear_sticky) begin
            loss_count <= COUNT_WIDTH'(1);
         end else if (loss_count != '1) begin
            loss_count <= loss_count + COUNT_WIDTH'(1);
         end
      end else if (clear_sticky) begin
         lock_lost  <= 1'b0;
         loss_count <= '0;
      end
   end

endmodule
